// File: rtl/handshake_constant_repeat_if.sv
// Control and output handshake channels of the constant-repeat source.
// master = the source block, slave = its environment.
interface handshake_constant_repeat_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  last;

  modport master (
    input  ctrl_valid, outs_ready,
    output ctrl_ready, outs, outs_valid, last
  );

  modport slave (
    output ctrl_valid, outs_ready,
    input  ctrl_ready, outs, outs_valid, last
  );
endinterface

// File: rtl/handshake_constant_repeat.sv
// Emits REPEAT tokens of constant VALUE per accepted control token, last on the final one.
// Latency: one cycle from control accept to first output; groups stream back-to-back.
// Backpressure: outs_ready=0 freezes the slot; ctrl_ready only opens when idle or last token leaves.
module handshake_constant_repeat #(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned VALUE      = 0,
  parameter int          REPEAT     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  handshake_constant_repeat_if.master  bus
);

  localparam int CNT_W = (REPEAT > 2) ? $clog2(REPEAT) : 1;
  localparam logic [DATA_WIDTH-1:0] CONST_DAT = DATA_WIDTH'(VALUE);
  localparam logic [CNT_W-1:0]      REM_INIT  = CNT_W'(REPEAT - 1);
  localparam logic                  LAST_INIT = (REPEAT == 1);

  generate
    if (REPEAT < 1) begin : g_bad_repeat
      $error("handshake_constant_repeat: REPEAT must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                state;
  logic [CNT_W-1:0]      rem;
  logic [DATA_WIDTH-1:0] outs_dat;
  logic                  last_q;
  logic                  rem_zero;
  logic                  o_fire;
  logic                  c_fire;
  logic                  ctrl_rdy;

  assign rem_zero = (rem == '0);
  assign o_fire   = (state == EMIT) & bus.outs_ready;
  // Accepting on the cycle the final token leaves keeps back-to-back groups gapless.
  assign ctrl_rdy = rst & ((state == IDLE) | (bus.outs_ready & rem_zero));
  assign c_fire   = bus.ctrl_valid & ctrl_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rem      <= '0;
      outs_dat <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c_fire) begin
            state    <= EMIT;
            rem      <= REM_INIT;
            outs_dat <= CONST_DAT;
            last_q   <= LAST_INIT;
          end
        end
        EMIT: begin
          if (o_fire) begin
            if (!rem_zero) begin
              rem    <= rem - CNT_W'(1);
              last_q <= (rem == CNT_W'(1));
            end else if (c_fire) begin
              rem    <= REM_INIT;
              last_q <= LAST_INIT;
            end else begin
              state    <= IDLE;
              outs_dat <= '0;
              last_q   <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rem      <= '0;
          outs_dat <= '0;
          last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctrl_ready = ctrl_rdy;
  assign bus.outs_valid = (state == EMIT);
  assign bus.outs       = outs_dat;
  assign bus.last       = last_q;

endmodule

// File: doc/handshake_constant_repeat.md
# handshake_constant_repeat

Parametrised handshake constant source with a registered output slot and a per-token repeat count. Each token accepted on the control channel causes the block to emit `REPEAT` output tokens, all carrying the constant `VALUE`. A `last` flag marks the final token of each group. The block sits in dataflow-generated datapaths wherever a constant must be produced at the control rate or at a fixed multiple of it (loop bounds, repeated coefficients). The output is registered to break the combinational valid path.

## Interface

Parameters:
- `DATA_WIDTH`, 32, width of `outs`.
- `VALUE`, 0, constant emitted. Only bits `[DATA_WIDTH-1:0]` are used.
- `REPEAT`, 1, number of output tokens per accepted control token. Must be ≥1; `REPEAT`=0 is an elaboration error.
- Local `CNT_W` = max(1, clog2(`REPEAT`)), width of the remaining-token counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (`rst`=0 resets).
- `ctrl_valid`  in  1  control token offered.
- `ctrl_ready`  out  1  control token accepted when high with `ctrl_valid`.
- `outs`  out  `DATA_WIDTH`  constant data; `VALUE` while `outs_valid`=1, else 0.
- `outs_valid`  out  1  output token present (registered).
- `outs_ready`  in  1  downstream accepts.
- `last`  out  1  high with `outs_valid` on the final token of a group.

## Operation

- State: `outs_valid` register (IDLE when 0, EMIT when 1) and `rem` counter (`CNT_W` bits) = tokens still to present after the current one.
- Events: `c_fire` = `ctrl_valid & ctrl_ready`; `o_fire` = `outs_valid & outs_ready`.
- `ctrl_ready` = `rst` & (!`outs_valid` | (`outs_ready` & `rem`==0)).
  - A new control token is accepted in the same cycle the last token of the previous group leaves.
- IDLE, `c_fire`: go to EMIT, `outs_valid`<=1, `rem`<=`REPEAT`-1.
- EMIT, `o_fire`, `rem`≠0: `rem`<=`rem`-1, `outs_valid` stays 1.
- EMIT, `o_fire`, `rem`==0, `c_fire` same cycle: `outs_valid` stays 1, `rem`<=`REPEAT`-1 (new group, no bubble).
- EMIT, `o_fire`, `rem`==0, no `c_fire`: return to IDLE, `outs_valid`<=0.
- EMIT, no `o_fire`: hold all state. `outs` and `last` stay stable (valid-stable rule).
- `last` = `outs_valid` & (`rem`==0).
- `outs` = `outs_valid` ? `VALUE`[`DATA_WIDTH`-1:0] : 0. It may be a register or a gated constant, provided it is glitch-free at the clock edge.
- With `REPEAT`=1, `rem` is always 0 and the block acts as a one-slot pipelined constant with full throughput.

## Timing

- Reset (`rst`=0, asynchronous): `outs_valid`=0, `rem`=0, `outs`=0, `last`=0, `ctrl_ready`=0.
  - After deassertion, `ctrl_ready`=1 from the first edge.
  - Reset mid-group discards the remaining tokens. No token is emitted after release until a new `c_fire`.
- Latency: `c_fire` at edge N → `outs_valid`=1 after edge N (visible in cycle N+1).
- There is no combinational path from `ctrl_valid` to any output.
- There is a combinational path from `outs_ready` to `ctrl_ready`. This is intended; the upstream must not loop it back combinationally.
- Throughput: one output token per cycle under continuous `outs_ready`=1. A group takes exactly `REPEAT` cycles, and back-to-back groups have zero gap.
- Backpressure: `outs_ready`=0 freezes `rem` and `outs_valid`. `ctrl_ready` is 0 during EMIT unless the last token is leaving.

## Test plan

Use `DATA_WIDTH`=6, `VALUE`=19, `REPEAT`=3 unless noted.

- **Reset:** hold `rst`=0 for 3 cycles with `ctrl_valid`=1 → `outs_valid`=0, `outs`=0, `ctrl_ready`=0. Release → `ctrl_ready`=1 in the next cycle.
- **Single group:** one `ctrl_valid` pulse, `outs_ready`=1 → `outs_valid` high for exactly 3 consecutive cycles starting the cycle after accept. `outs`=6'b010011 on each. `last`=1 only on the 3rd.
- **Back-to-back:** `ctrl_valid` held 1, `outs_ready`=1 for 12 cycles → 4 accepts, one every 3 cycles. `outs_valid` continuously 1 after the first cycle. `last` pattern 0,0,1 repeating.
- **Backpressure:** single group with `outs_ready` pattern 1,0,0,1,0,1 → exactly 3 transfers. `outs`/`last` stable while stalled. `ctrl_ready`=0 until the 3rd transfer cycle.
- **REPEAT=1:** `ctrl_valid`=1, random `outs_ready` for 200 cycles → #accepts = #transfers (±1 in flight). `last`=`outs_valid` always.
- **Async reset mid-group:** assert `rst`=0 between edges after the 1st transfer → `outs_valid` drops immediately without a clock edge. After release no further outputs appear until a new control token.
